// File: rtl/video_window_if.sv
// ----------------------------------------------------------------------------
// video_window_if : core-side video stream and measurement bundle for video_window
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface video_window_if #(
   parameter int CNT_W = 12
);
   logic             ce_pix;
   logic [7:0]       r_in;
   logic [7:0]       g_in;
   logic [7:0]       b_in;
   logic             hs_in;
   logic             vs_in;
   logic             hblank_in;
   logic             vblank_in;
   logic             clip_en;

   logic             ce_out;
   logic [7:0]       r_out;
   logic [7:0]       g_out;
   logic [7:0]       b_out;
   logic             hs_out;
   logic             vs_out;
   logic             hblank_out;
   logic             vblank_out;
   logic [CNT_W-1:0] act_width;
   logic [CNT_W-1:0] act_height;
   logic             meas_valid;

   modport master (
      output ce_pix, r_in, g_in, b_in, hs_in, vs_in, hblank_in, vblank_in, clip_en,
      input  ce_out, r_out, g_out, b_out, hs_out, vs_out, hblank_out, vblank_out,
             act_width, act_height, meas_valid
   );

   modport slave (
      input  ce_pix, r_in, g_in, b_in, hs_in, vs_in, hblank_in, vblank_in, clip_en,
      output ce_out, r_out, g_out, b_out, hs_out, vs_out, hblank_out, vblank_out,
             act_width, act_height, meas_valid
   );
endinterface

`default_nettype wire

// File: rtl/video_window.sv
// ----------------------------------------------------------------------------
// video_window : registers the core video stream, optionally clips the sides by
//                widening HBlank, and measures stable active width/height.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module video_window #(
   parameter int CLIP_PIX = 8,
   parameter int CNT_W    = 12
) (
   input  wire logic       CLK_VIDEO,
   input  wire logic       reset,
   video_window_if.slave   vid
);

   localparam logic [CNT_W-1:0] C_MAX   = '1;
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_CLIP  = CNT_W'(CLIP_PIX);
   localparam logic [CNT_W-1:0] C_CLIP2 = CNT_W'(2 * CLIP_PIX);

   logic             r_hb_d;
   logic             r_vb_d;
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] r_vcnt;
   logic [CNT_W-1:0] r_line_w;
   logic             r_clip_act;
   logic [CNT_W-1:0] r_prev_w;
   logic [CNT_W-1:0] r_prev_h;

   logic             w_line_end;
   logic             w_frame_end;
   logic [CNT_W-1:0] w_line_w_new;
   logic [CNT_W-1:0] w_vcnt_new;
   logic             w_hb;
   logic             w_blank;
   logic             w_meas_match;

   always_comb begin
      w_line_end   = vid.hblank_in & ~r_hb_d;
      w_frame_end  = vid.vblank_in & ~r_vb_d;
      w_line_w_new = (w_line_end && r_hcnt != '0) ? r_hcnt : r_line_w;
      w_vcnt_new   = (w_line_end && !vid.vblank_in && r_vcnt != C_MAX) ? r_vcnt + C_ONE : r_vcnt;
      // r_hcnt is the index of the pixel being presented; r_line_w is the previous line
      w_hb         = vid.hblank_in |
                     (r_clip_act & ((r_hcnt < C_CLIP) | (r_hcnt >= r_line_w - C_CLIP)));
      w_blank      = w_hb | vid.vblank_in;
      w_meas_match = (w_line_w_new == r_prev_w) && (w_vcnt_new == r_prev_h) && (w_vcnt_new != '0);
   end

   always_ff @(posedge CLK_VIDEO) begin
      if (reset) begin
         vid.ce_out     <= 1'b0;
         vid.r_out      <= '0;
         vid.g_out      <= '0;
         vid.b_out      <= '0;
         vid.hs_out     <= 1'b0;
         vid.vs_out     <= 1'b0;
         vid.hblank_out <= 1'b1;
         vid.vblank_out <= 1'b1;
         vid.act_width  <= '0;
         vid.act_height <= '0;
         vid.meas_valid <= 1'b0;
         r_hb_d         <= 1'b1;
         r_vb_d         <= 1'b1;
         r_hcnt         <= '0;
         r_vcnt         <= '0;
         r_line_w       <= '0;
         r_clip_act     <= 1'b0;
         r_prev_w       <= '0;
         r_prev_h       <= '0;
      end else begin
         vid.ce_out <= vid.ce_pix;
         if (vid.ce_pix) begin
            vid.r_out      <= w_blank ? 8'h00 : vid.r_in;
            vid.g_out      <= w_blank ? 8'h00 : vid.g_in;
            vid.b_out      <= w_blank ? 8'h00 : vid.b_in;
            vid.hs_out     <= vid.hs_in;
            vid.vs_out     <= vid.vs_in;
            vid.hblank_out <= w_hb;
            vid.vblank_out <= vid.vblank_in;
            r_hb_d         <= vid.hblank_in;
            r_vb_d         <= vid.vblank_in;

            if (vid.hblank_in)
               r_hcnt <= '0;
            else if (r_hcnt != C_MAX)
               r_hcnt <= r_hcnt + C_ONE;

            if (w_line_end) begin
               r_line_w   <= w_line_w_new;
               r_clip_act <= vid.clip_en && (w_line_w_new > C_CLIP2);
            end

            // A coincident line end has already been folded into w_vcnt_new
            if (w_frame_end) begin
               r_vcnt   <= '0;
               r_prev_w <= w_line_w_new;
               r_prev_h <= w_vcnt_new;
               if (w_meas_match) begin
                  vid.act_width  <= w_line_w_new;
                  vid.act_height <= w_vcnt_new;
                  vid.meas_valid <= 1'b1;
               end else begin
                  vid.meas_valid <= 1'b0;
               end
            end else begin
               r_vcnt <= w_vcnt_new;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_video_window.sv
// ----------------------------------------------------------------------------
// tb_video_window : directed frames with a queue scoreboard for video_window
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_video_window;

   localparam int HB = 8;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hb;
      logic       vb;
      logic       hs;
      logic       vs;
   } exp_t;

   logic CLK_VIDEO = 1'b0;
   logic reset     = 1'b1;
   always #5 CLK_VIDEO = ~CLK_VIDEO;

   video_window_if #(.CNT_W(12)) vif ();

   video_window #(.CLIP_PIX(8), .CNT_W(12)) dut (
      .CLK_VIDEO (CLK_VIDEO),
      .reset     (reset),
      .vid       (vif.slave)
   );

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   div     = 1;
   bit   mon_on  = 1'b0;
   logic ce_s    = 1'b0;
   logic rst_s   = 1'b1;

   always @(posedge CLK_VIDEO) begin
      ce_s  <= vif.ce_pix;
      rst_s <= reset;
   end

   // Monitor: ce_out every clock, reset values while in reset, else scoreboard pop
   always @(negedge CLK_VIDEO) begin
      exp_t e;
      exp_t a;
      if (mon_on) begin
         n_tests++;
         if (vif.ce_out !== (rst_s ? 1'b0 : ce_s)) begin
            n_fail++;
            $display("FAIL ce_out: got %b expected %b", vif.ce_out, rst_s ? 1'b0 : ce_s);
         end
         a = {vif.r_out, vif.g_out, vif.b_out, vif.hblank_out, vif.vblank_out, vif.hs_out, vif.vs_out};
         if (rst_s) begin
            n_tests++;
            if (a !== {24'h0, 4'b1100} || vif.meas_valid !== 1'b0 ||
                vif.act_width !== 12'd0 || vif.act_height !== 12'd0) begin
               n_fail++;
               $display("FAIL reset_state: got out=%h aw=%0d ah=%0d mv=%b expected out=%h aw=0 ah=0 mv=0",
                        a, vif.act_width, vif.act_height, vif.meas_valid, {24'h0, 4'b1100});
            end
         end else if (vif.ce_out === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_empty: got output %h expected no output", a);
            end else begin
               e = q.pop_front();
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL pixel t=%0t: got rgb=%h_%h_%h hb=%b vb=%b hs=%b vs=%b expected rgb=%h_%h_%h hb=%b vb=%b hs=%b vs=%b",
                           $time, a.r, a.g, a.b, a.hb, a.vb, a.hs, a.vs,
                           e.r, e.g, e.b, e.hb, e.vb, e.hs, e.vs);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK_VIDEO);
      #1;
   endtask

   // One ce cycle; with div==2 a ce=0 cycle of junk inputs follows
   task automatic px(input logic hb, input logic vb, input logic hs, input logic vs,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic exp_hb);
      exp_t e;
      vif.ce_pix    = 1'b1;
      vif.hblank_in = hb;
      vif.vblank_in = vb;
      vif.hs_in     = hs;
      vif.vs_in     = vs;
      vif.r_in      = r;
      vif.g_in      = g;
      vif.b_in      = b;
      e.r  = (exp_hb | vb) ? 8'h00 : r;
      e.g  = (exp_hb | vb) ? 8'h00 : g;
      e.b  = (exp_hb | vb) ? 8'h00 : b;
      e.hb = exp_hb;
      e.vb = vb;
      e.hs = hs;
      e.vs = vs;
      q.push_back(e);
      tick();
      if (div == 2) begin
         vif.ce_pix    = 1'b0;
         vif.hblank_in = 1'($urandom);
         vif.vblank_in = 1'($urandom);
         vif.hs_in     = 1'($urandom);
         vif.vs_in     = 1'($urandom);
         vif.r_in      = 8'($urandom);
         vif.g_in      = 8'($urandom);
         vif.b_in      = 8'($urandom);
         tick();
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         px(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 1'b1);
         vif.ce_pix = 1'b0;
         tick();
      end
   endtask

   // clipw = 0: no clipping expected; else blank x<8 and x>=clipw-8
   task automatic line(input int w, input int ln, input logic vb, input int clipw,
                       input logic vs_line, input int from);
      for (int x = from; x < w; x++)
         px(1'b0, vb, 1'b0, vs_line, 8'h5A, 8'(x), 8'(ln + 16),
            (clipw != 0) && (x < 8 || x >= clipw - 8));
      for (int k = 0; k < HB; k++)
         px(1'b1, vb, (k >= 2 && k < 6), vs_line, 8'hC3, 8'hC3, 8'hC3, 1'b1);
   endtask

   task automatic frame(input int w, input int h, input int nvb,
                        input int clipf, input int clipr, input int first);
      for (int l = first; l < h + nvb; l++)
         line(w, l, (l >= h), (l == first) ? clipf : clipr, (l == h), 0);
   endtask

   task automatic check_meas(input string name, input int w, input int h, input logic v);
      n_tests++;
      if (vif.act_width !== 12'(w) || vif.act_height !== 12'(h) || vif.meas_valid !== v) begin
         n_fail++;
         $display("FAIL %s: got w=%0d h=%0d valid=%b expected w=%0d h=%0d valid=%b",
                  name, vif.act_width, vif.act_height, vif.meas_valid, w, h, v);
      end
   endtask

   initial begin
      vif.ce_pix    = 1'b0;
      vif.hblank_in = 1'b1;
      vif.vblank_in = 1'b1;
      vif.hs_in     = 1'b0;
      vif.vs_in     = 1'b0;
      vif.r_in      = 8'hFF;
      vif.g_in      = 8'hFF;
      vif.b_in      = 8'hFF;
      vif.clip_en   = 1'b0;
      tick();
      mon_on = 1'b1;

      // Reset held 3 clocks with ce toggling and non-zero colour on the inputs
      for (int i = 0; i < 3; i++) begin
         vif.ce_pix = ~vif.ce_pix;
         tick();
      end
      vif.ce_pix = 1'b0;
      reset = 1'b0;
      idle(4);

      // Unclipped 320-wide frames; second frame end makes the measurement valid
      frame(320, 4, 2, 0, 0, 0);
      check_meas("first_frame", 0, 0, 1'b0);
      frame(320, 4, 2, 0, 0, 0);
      check_meas("second_frame", 320, 4, 1'b1);

      // Clipping enabled at frame start: first line still unclipped
      vif.clip_en = 1'b1;
      frame(320, 4, 2, 0, 320, 0);
      check_meas("clipped_width_raw", 320, 4, 1'b1);

      // Narrow lines: first one still clipped against 320, then 12 and 16 suppress it
      frame(12, 4, 2, 320, 0, 0);
      check_meas("narrow12", 320, 4, 1'b0);
      frame(16, 4, 2, 0, 0, 0);
      check_meas("narrow16_a", 320, 4, 1'b0);
      frame(16, 4, 2, 0, 0, 0);
      check_meas("narrow16_b", 16, 4, 1'b1);
      vif.clip_en = 1'b0;

      // Alternating heights, one frame with ce at half rate
      frame(320, 5, 2, 0, 0, 0);
      check_meas("alt_h5", 16, 4, 1'b0);
      div = 2;
      frame(320, 4, 2, 0, 0, 0);
      div = 1;
      check_meas("alt_h4", 16, 4, 1'b0);
      frame(320, 5, 2, 0, 0, 0);
      check_meas("alt_h5_again", 16, 4, 1'b0);
      frame(320, 5, 2, 0, 0, 0);
      check_meas("stable_h5", 320, 5, 1'b1);

      // Reset at hcnt=100 of line 1, then finish that frame and two full ones
      line(320, 0, 1'b0, 0, 1'b0, 0);
      for (int x = 0; x < 100; x++)
         px(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'(x), 8'h11, 1'b0);
      reset = 1'b1;
      vif.ce_pix = 1'b1;
      tick();
      vif.ce_pix = 1'b0;
      tick();
      reset = 1'b0;
      line(320, 1, 1'b0, 0, 1'b0, 100);
      frame(320, 4, 2, 0, 0, 2);
      check_meas("after_reset_partial", 0, 0, 1'b0);
      frame(320, 4, 2, 0, 0, 0);
      check_meas("after_reset_full1", 0, 0, 1'b0);
      frame(320, 4, 2, 0, 0, 0);
      check_meas("after_reset_full2", 320, 4, 1'b1);

      idle(3);
      tick();
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/video_window.md
Name: video_window

Overview:
- Pixel-domain conditioning stage between the Atari 5200 core video outputs (R/G/B, HSync/VSync, HBlank/VBlank, pixel enable) and video_mixer.
- Registers the video stream on CLK_VIDEO and applies optional side clipping by widening HBlank symmetrically.
- Measures active width and height per frame and flags them stable after two identical frames, for aspect/scale logic.

Parameters:
- CLIP_PIX, 8, pixels blanked on each side when clipping is enabled
- CNT_W, 12, width of the pixel and line counters and of the measurement outputs

Ports:
- clk  in  1  CLK_VIDEO
- reset  in  1  synchronous, active-high
- ce_pix  in  1  pixel enable from core
- r_in/g_in/b_in  in  8 each  core colour
- hs_in, vs_in  in  1 each  core sync
- hblank_in, vblank_in  in  1 each  core blanking
- clip_en  in  1  enable side clipping; sampled at HBlank rising edge
- ce_out  in→out  1  ce_pix delayed 1 clk
- r_out/g_out/b_out  out  8 each  registered colour, zero whenever blanked
- hs_out, vs_out  out  1 each  registered sync
- hblank_out, vblank_out  out  1 each  registered and clipped blanking
- act_width  out  CNT_W  measured active pixels per line
- act_height  out  CNT_W  measured active lines per frame
- meas_valid  out  1  width/height stable for 2 consecutive frames

Behaviour:
- All state updates only on clk edges where ce_pix=1, except ce_out, which updates every clk.
- Latency: outputs reflect the inputs of the previous ce_pix cycle.
- Reset values:
  - r/g/b_out=0, hs_out=vs_out=0, hblank_out=vblank_out=1, ce_out=0.
  - act_width=act_height=0, meas_valid=0.
  - Internal counters and the stored line width are 0.
- Reset mid-line takes priority: all outputs return to reset values on the same edge.
- hcnt:
  - Cleared on a ce cycle with hblank_in=1.
  - Increments on each ce cycle with hblank_in=0.
  - Saturates at 2^CNT_W-1 (no wrap).
- Line end is the ce cycle where hblank_in goes 0→1:
  - line_w <= hcnt, provided hcnt≠0.
  - clip_act <= clip_en && (line_w_new > 2*CLIP_PIX).
  - If vblank_in=0, vcnt increments (saturating).
- Clipping: when clip_act=1, hblank_out=1 if hcnt<CLIP_PIX or hcnt>=line_w-CLIP_PIX. line_w here is the previous line's width.
  - Otherwise hblank_out=hblank_in.
- When line_w ≤ 2*CLIP_PIX, clipping is off for the next line (pass-through).
- clip_en changes take effect only at the next line end, never mid-line.
- r/g/b_out = input colour unless hblank_out or vblank_in after clipping, in which case 0.
- vblank_out=vblank_in, hs_out=hs_in, vs_out=vs_in, all registered.
- Frame end is the ce cycle where vblank_in goes 0→1:
  - cand_w <= line_w, cand_h <= vcnt, and vcnt is cleared.
  - If cand_w==prev_w and cand_h==prev_h and cand_h≠0: act_width/act_height load the candidate and meas_valid=1.
  - Else meas_valid=0 and act_* hold their old values.
  - prev_* <= cand_*.
- Frame with zero active lines: meas_valid=0.
- A line end and a frame end on the same ce cycle: the line is counted first, then latched into cand_h.
- act_width is not reduced by clipping: it reports the raw active width.

Test Plan:
- Reset asserted for 3 clk with ce_pix toggling → hblank_out=vblank_out=1, RGB=0, meas_valid=0, ce_out=0; after release, ce_out follows ce_pix one clk late.
- 320-pixel lines, 240 active lines, clip_en=0, RGB=0x5A → output RGB=0x5A during active area at one ce latency. After the 2nd frame end act_width=320, act_height=240, meas_valid=1.
- Same stream with clip_en=1 from frame start → first line unclipped. Later lines: hblank_out=1 for hcnt 0..7 and 312..319, RGB=0 there; act_width remains 320.
- Line width 12 with clip_en=1 → clipping suppressed (12≤16), hblank_out equals hblank_in.
- Frame heights alternate 240/241 → meas_valid stays 0 and act_height holds the last stable value. Two 241 frames → act_height=241, meas_valid=1.
- Reset asserted mid-line at hcnt=100, released, then normal frames → counters restart from 0 and meas_valid returns after two full identical frames.
